// File: rtl/tsm_sbox_share_accumulator.sv
// XOR-accumulates time-multiplexed TSM S-box partial terms into per-share output registers.
// Optional macro TSM_OUT_REFRESH_EN adds an 8-bit rnd input that re-masks shares 0 and NUM_SHARES-1 on completion.
module tsm_sbox_share_accumulator #(
    parameter int NUM_SHARES = 2,
    parameter int NUM_TERMS  = 4,
    parameter int SIDX_W     = (NUM_SHARES > 1) ? $clog2(NUM_SHARES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    term_valid,
    output logic                    term_ready,
    input  logic [7:0]              term_data,
    input  logic [SIDX_W-1:0]       term_sidx,
    input  logic                    term_last,
`ifdef TSM_OUT_REFRESH_EN
    input  logic [7:0]              rnd,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*NUM_SHARES-1:0] out_shares,
    output logic                    err
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_acc [NUM_SHARES];
    logic             r_out_valid;
    logic             r_err;

    logic             w_accept;
    logic             w_cnt_at_last;
    logic             w_final;
    logic             w_out_hs;
    logic             w_sidx_bad;
    logic             w_last_bad;
    logic [7:0]       w_rnd;

    // A term only reaches the accumulator whose index it carries, so shares never mix.
    function automatic logic [7:0] f_term_contrib(
        input logic [SIDX_W-1:0] sidx,
        input logic [7:0]        data,
        input int                k
    );
        if (int'(sidx) == k) begin
            return data;
        end else begin
            return 8'h00;
        end
    endfunction

    // Refresh mask lands on the first and last share so the share XOR is unchanged.
    function automatic logic [7:0] f_refresh_contrib(
        input logic [7:0] mask,
        input int         k
    );
        if ((k == 0) || (k == NUM_SHARES - 1)) begin
            return mask;
        end else begin
            return 8'h00;
        end
    endfunction

    assign term_ready    = ~rst & (r_state != S_HOLD);
    assign w_accept      = term_valid & term_ready;
    assign w_cnt_at_last = (r_cnt == CNT_W'(NUM_TERMS - 1));
    assign w_final       = w_accept & w_cnt_at_last;
    assign w_out_hs      = r_out_valid & out_ready & (r_state == S_HOLD);
    assign w_sidx_bad    = ({1'b0, term_sidx} >= (SIDX_W + 1)'(NUM_SHARES));
    assign w_last_bad    = (term_last != w_cnt_at_last);

`ifdef TSM_OUT_REFRESH_EN
    assign w_rnd = w_final ? rnd : 8'h00;
`else
    assign w_rnd = 8'h00;
`endif

    // Next-state selection for the collect / hold sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_final) begin
                    w_state_nxt = S_HOLD;
                end else if (w_accept) begin
                    w_state_nxt = S_ACCUM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (w_final) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_HOLD: begin
                if (w_out_hs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, term counter, sticky error and output-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == S_HOLD);
            if (w_out_hs) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_accept && (w_sidx_bad || w_last_bad)) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Per-share accumulators; cleared by reset and by the output handshake.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SHARES; k++) begin
            if (rst || w_out_hs) begin
                r_acc[k] <= 8'h00;
            end else if (w_accept) begin
                r_acc[k] <= r_acc[k] ^ f_term_contrib(term_sidx, term_data, k)
                                     ^ f_refresh_contrib(w_rnd, k);
            end else begin
                r_acc[k] <= r_acc[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SHARES; g++) begin : g_out
            assign out_shares[8*g +: 8] = r_acc[g];
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_tsm_sbox_share_accumulator.sv
// Self-checking bench for tsm_sbox_share_accumulator: directed scenarios plus randomized traffic
// against a term-list reference model. Define TSM_OUT_REFRESH_EN to also exercise output refresh.
module tb_tsm_sbox_share_accumulator;

    localparam int NS = 2;
    localparam int NT = 4;
    localparam int SW = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            term_valid = 1'b0;
    logic            term_ready;
    logic [7:0]      term_data = 8'h00;
    logic [SW-1:0]   term_sidx = '0;
    logic            term_last = 1'b0;
`ifdef TSM_OUT_REFRESH_EN
    logic [7:0]      rnd = 8'h00;
`endif
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [8*NS-1:0] out_shares;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of terms accepted in the current set.
    int         q_sidx[$];
    logic [7:0] q_data[$];
    bit         m_hold = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] m_rnd  = 8'h00;

    logic            s_out_valid;
    logic [8*NS-1:0] s_out_shares;
    logic            s_err;
    logic            s_term_ready;

    tsm_sbox_share_accumulator #(.NUM_SHARES(NS), .NUM_TERMS(NT)) dut (
        .clk(clk),
        .rst(rst),
        .term_valid(term_valid),
        .term_ready(term_ready),
        .term_data(term_data),
        .term_sidx(term_sidx),
        .term_last(term_last),
`ifdef TSM_OUT_REFRESH_EN
        .rnd(rnd),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_shares(out_shares),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [8*NS-1:0] exp_shares();
        logic [8*NS-1:0] res;
        res = '0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_sidx[i] < NS) res[8*q_sidx[i] +: 8] = res[8*q_sidx[i] +: 8] ^ q_data[i];
        end
        res[7:0] = res[7:0] ^ m_rnd;
        res[8*NS-1 -: 8] = res[8*NS-1 -: 8] ^ m_rnd;
        return res;
    endfunction

    // One clock: compare DUT to model at the negedge, then advance the model across the posedge.
    task automatic cycle(output bit accepted);
        bit hs;
        accepted = 1'b0;
        @(negedge clk);
        s_out_valid  = out_valid;
        s_out_shares = out_shares;
        s_err        = err;
        s_term_ready = term_ready;
        if (rst) begin
            n_checks++;
            if (term_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_term_ready: got %b expected 0", term_ready);
            end
            @(posedge clk);
            #1;
            q_sidx.delete();
            q_data.delete();
            m_hold = 1'b0;
            m_err  = 1'b0;
            m_rnd  = 8'h00;
            return;
        end
        n_checks += 4;
        if (term_ready !== !m_hold) begin
            n_fail++;
            $display("FAIL model_term_ready: got %b expected %b", term_ready, !m_hold);
        end
        if (out_valid !== m_hold) begin
            n_fail++;
            $display("FAIL model_out_valid: got %b expected %b", out_valid, m_hold);
        end
        if (out_shares !== exp_shares()) begin
            n_fail++;
            $display("FAIL model_out_shares: got %h expected %h", out_shares, exp_shares());
        end
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL model_err: got %b expected %b", err, m_err);
        end
        accepted = term_valid && !m_hold;
        hs = m_hold && out_ready;
        if (accepted) begin
            if ((q_data.size() == NT - 1) != term_last) m_err = 1'b1;
            if (int'(term_sidx) >= NS) m_err = 1'b1;
            q_sidx.push_back(int'(term_sidx));
            q_data.push_back(term_data);
            if (q_data.size() == NT) begin
                m_hold = 1'b1;
`ifdef TSM_OUT_REFRESH_EN
                m_rnd = rnd;
`endif
            end
        end
        if (hs) begin
            m_hold = 1'b0;
            q_sidx.delete();
            q_data.delete();
            m_rnd = 8'h00;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sidx, input logic [7:0] data, input bit last);
        bit acc;
        int guard;
        term_valid = 1'b1;
        term_sidx  = SW'(sidx);
        term_data  = data;
        term_last  = last;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            cycle(acc);
            guard++;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic idle();
        bit acc;
        term_valid = 1'b0;
        term_last  = 1'b0;
        cycle(acc);
    endtask

    task automatic send_basic_set();
        send(0, 8'h5A, 1'b0);
        send(1, 8'h3C, 1'b0);
        send(0, 8'h0F, 1'b0);
        send(1, 8'hF0, 1'b1);
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        idle();
        n_checks += 4;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", s_out_valid); end
        if (s_out_shares !== 16'h0000) begin n_fail++; $display("FAIL reset_out_shares: got %h expected 0000", s_out_shares); end
        if (s_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", s_err); end
        if (s_term_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b expected 1", s_term_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_basic_set();
        idle();
        n_checks += 4;
        if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency: got out_valid %b expected 1", s_out_valid); end
        if (s_out_shares !== 16'hCC55) begin n_fail++; $display("FAIL b2b_shares: got %h expected cc55", s_out_shares); end
        if ((s_out_shares[7:0] ^ s_out_shares[15:8]) !== 8'h99) begin
            n_fail++;
            $display("FAIL b2b_xor: got %h expected 99", s_out_shares[7:0] ^ s_out_shares[15:8]);
        end
        if (s_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", s_err); end
        idle();
        n_checks++;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got out_valid %b expected 0", s_out_valid); end
    endtask

    task automatic test_hold();
        bit acc;
        out_ready = 1'b0;
        send_basic_set();
        term_valid = 1'b1;
        term_sidx  = SW'(0);
        term_data  = 8'h11;
        term_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(acc);
            n_checks += 3;
            if (s_term_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %b expected 0", s_term_ready); end
            if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", s_out_valid); end
            if (s_out_shares !== 16'hCC55) begin n_fail++; $display("FAIL hold_shares: got %h expected cc55", s_out_shares); end
        end
        out_ready = 1'b1;
        cycle(acc);
        send(0, 8'h11, 1'b0);
        idle();
        n_checks++;
        if (s_out_shares !== 16'h0011) begin n_fail++; $display("FAIL hold_fresh_start: got %h expected 0011", s_out_shares); end
        send(1, 8'h22, 1'b0);
        send(0, 8'h44, 1'b0);
        send(1, 8'h88, 1'b1);
        idle();
        n_checks++;
        if (s_out_shares !== 16'hAA55) begin n_fail++; $display("FAIL hold_second_set: got %h expected aa55", s_out_shares); end
        idle();
    endtask

    task automatic test_last_error();
        out_ready = 1'b1;
        send(0, 8'h01, 1'b0);
        send(1, 8'h02, 1'b1);
        idle();
        n_checks++;
        if (s_err !== 1'b1) begin n_fail++; $display("FAIL last_early_err: got %b expected 1", s_err); end
        send(0, 8'h03, 1'b0);
        send(1, 8'h04, 1'b1);
        idle();
        n_checks += 3;
        if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL last_completes: got %b expected 1", s_out_valid); end
        if (s_out_shares !== 16'h0602) begin n_fail++; $display("FAIL last_shares: got %h expected 0602", s_out_shares); end
        if (s_err !== 1'b1) begin n_fail++; $display("FAIL last_sticky: got %b expected 1", s_err); end
        idle();
    endtask

    task automatic test_mid_reset();
        bit acc;
        out_ready = 1'b1;
        send(0, 8'hAA, 1'b0);
        send(1, 8'hBB, 1'b0);
        term_valid = 1'b0;
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        idle();
        n_checks += 3;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b expected 0", s_out_valid); end
        if (s_err !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %b expected 0", s_err); end
        if (s_out_shares !== 16'h0000) begin n_fail++; $display("FAIL mrst_shares: got %h expected 0000", s_out_shares); end
        send_basic_set();
        idle();
        n_checks++;
        if (s_out_shares !== 16'hCC55) begin n_fail++; $display("FAIL mrst_fresh_set: got %h expected cc55", s_out_shares); end
        idle();
    endtask

    task automatic test_gapped();
        out_ready = 1'b1;
        send(0, 8'h5A, 1'b0);
        idle();
        send(1, 8'h3C, 1'b0);
        idle();
        send(0, 8'h0F, 1'b0);
        idle();
        send(1, 8'hF0, 1'b1);
        idle();
        n_checks += 2;
        if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b expected 1", s_out_valid); end
        if (s_out_shares !== 16'hCC55) begin n_fail++; $display("FAIL gap_shares: got %h expected cc55", s_out_shares); end
        idle();
    endtask

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 149) == 0);
            term_valid = $urandom_range(0, 3) != 0;
            term_sidx  = SW'($urandom_range(0, NS - 1));
            term_data  = 8'($urandom_range(0, 255));
            term_last  = (q_data.size() == NT - 1) ^ ($urandom_range(0, 15) == 0);
            out_ready  = $urandom_range(0, 1) != 0;
`ifdef TSM_OUT_REFRESH_EN
            rnd = 8'($urandom_range(0, 255));
`endif
            cycle(acc);
        end
        rst = 1'b0;
    endtask

`ifdef TSM_OUT_REFRESH_EN
    task automatic test_refresh();
        bit acc;
        term_valid = 1'b0;
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        out_ready = 1'b1;
        rnd = 8'h3E;
        send(0, 8'h5A, 1'b0);
        rnd = 8'h71;
        send(1, 8'h3C, 1'b0);
        rnd = 8'hC9;
        send(0, 8'h0F, 1'b0);
        rnd = 8'hA5;
        send(1, 8'hF0, 1'b1);
        rnd = 8'h17;
        idle();
        n_checks += 2;
        if (s_out_shares !== 16'h69F0) begin n_fail++; $display("FAIL refresh_shares: got %h expected 69f0", s_out_shares); end
        if ((s_out_shares[7:0] ^ s_out_shares[15:8]) !== 8'h99) begin
            n_fail++;
            $display("FAIL refresh_xor: got %h expected 99", s_out_shares[7:0] ^ s_out_shares[15:8]);
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_last_error();
        test_mid_reset();
        test_gapped();
        test_random();
`ifdef TSM_OUT_REFRESH_EN
        test_refresh();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tsm_sbox_share_accumulator.md
Name: tsm_sbox_share_accumulator

Overview:
- Downstream stage of the per-domain S-box term generators in the first-order TSM AES S-box datapath.
- Each generator produces 8-bit partial output terms for the eight S-box output bits. Inner-domain terms come per share domain; cross-domain terms come from the cross-domain generators.
- This block receives those terms time-multiplexed over a valid/ready stream and XOR-accumulates them into per-share 8-bit output registers.
- When a full set of terms has been collected, it presents the completed masked S-box output shares with a valid/ready handshake.

Parameters:
- NUM_SHARES, 2, number of output shares (domains); legal range 2..4.
- NUM_TERMS, 4, number of partial terms that make up one S-box output; legal range 2..16.
- SIDX_W, derived: max(1, $clog2(NUM_SHARES)); width of the share index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- term_valid  in  1  a partial term is presented.
- term_ready  out  1  block can accept a term this cycle.
- term_data  in  8  partial term; bit i contributes to S-box output bit i.
- term_sidx  in  SIDX_W  destination share domain of the term.
- term_last  in  1  producer marks the final term of the set.
- out_valid  out  1  completed output shares are available.
- out_ready  in  1  consumer accepts the output.
- out_shares  out  8*NUM_SHARES  share k occupies bits [8k+7:8k].
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: synchronous, active-high; `rst` sampled on the `clk` rising edge.
  - On reset: state=IDLE, accumulators=0, term counter=0, out_valid=0, out_shares=0, err=0, term_ready=0 in the reset cycle.
  - Reset mid-operation discards all partial accumulation.
- States:
  - IDLE: term_ready=1, counter=0, accumulators=0.
  - ACCUM: term_ready=1, at least one term accepted.
  - HOLD: term_ready=0, out_valid=1.
- Accept condition: term_valid & term_ready.
  - On accept, acc[term_sidx] ^= term_data and the counter increments.
  - IDLE moves to ACCUM on the first accept.
- Set completion: the accept that makes counter == NUM_TERMS moves the block to HOLD.
  - out_valid rises on the next cycle (latency 1 from the final accept).
  - out_shares is driven directly from the accumulator registers and must include the final term.
- Handshake in HOLD:
  - out_shares is held stable until out_valid & out_ready.
  - On that cycle the block returns to IDLE, clears the accumulators and counter, and out_valid=0 next cycle.
  - No term is accepted in HOLD, even when out_ready is high in the same cycle (no bypass). The next term can be accepted one cycle after the output handshake.
- term_last checking (err goes high on any violation):
  - term_last=1 on an accepted term while the counter is not about to reach NUM_TERMS.
  - term_last=0 on the NUM_TERMS-th accepted term.
  - The counter still governs completion; term_last never ends a set early.
- term_sidx >= NUM_SHARES: the term is accepted and counted but not accumulated, and err is set.
- err stays set until rst.
- No combinational path from term_valid to term_ready or from out_ready to out_valid.
- Shares must never be combined inside the block: each accumulator XORs only terms tagged with its own index.

Optional Feature:
- Macro: TSM_OUT_REFRESH_EN.
- With the macro defined:
  - Extra input port `rnd`, 8 bits, fresh randomness.
  - On the final accept cycle, `rnd` is XORed into acc[0] and into acc[NUM_SHARES-1] together with the term. The output sharing is therefore re-masked while the XOR of all shares is unchanged.
  - `rnd` is sampled only on that cycle.
- Without the macro: no `rnd` port and no refresh; outputs are the raw accumulated sums.

Test Plan:
- Defaults; terms (sidx0,0x5A),(1,0x3C),(0,0x0F),(1,0xF0,last), back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept; out_shares=0xCC55; XOR of shares=0x99; err=0.
- Same set with out_ready held 0 for 5 cycles while term_valid=1 -> term_ready=0 throughout; out_shares stays 0xCC55; after the handshake, a new set starts from zero accumulators.
- term_last asserted on the 2nd term -> err=1 and stays 1; output still completes after the 4th term.
- rst asserted after 2 accepted terms -> next cycle out_valid=0, err=0; a fresh 4-term set gives the correct result with no residue.
- term_valid gapped (valid every other cycle) -> result identical to the back-to-back case; the counter only advances on accepts.
- TSM_OUT_REFRESH_EN, rnd=0xA5 on the final accept -> out_shares=0x69F0 (share0=0x55^0xA5, share1=0xCC^0xA5); XOR of shares still 0x99.
